// File: rtl/timing_generator_pkg.sv
// timing_generator_pkg: timing generator register map, control bits and shared scheduler types.
// EXPOSURE_SCHEDULER_POL_EN adds the trig0 polarity beat to the scheduler state set.
package timing_generator_pkg;
    localparam int CTL_CONTROL    = 'h04;
    localparam int PARAM_PERIOD   = 'h10;
    localparam int TRIG0_START    = 'h20;
    localparam int TRIG0_END      = 'h21;
    localparam int TRIG0_POL      = 'h22;
    localparam int CTL_RUN_BIT    = 0;
    localparam int CTL_UPDATE_BIT = 1;
    localparam logic [31:0] CTL_GO = (32'd1 << CTL_RUN_BIT) | (32'd1 << CTL_UPDATE_BIT);
    typedef logic [31:0] timer_t;
    typedef logic [31:0] frames_t;
    typedef enum logic [2:0] {
        S_IDLE, S_PERIOD, S_START, S_END,
`ifdef EXPOSURE_SCHEDULER_POL_EN
        S_POL,
`endif
        S_CTL
    } sched_state_e;
    function automatic logic [31:0] byte_off(input int word);
        return 32'(word << 2);
    endfunction
endpackage

// File: rtl/axi4l_single_writer.sv
// axi4l_single_writer: one AXI4-Lite write beat; AW and W issue together, B is taken once both are accepted.
module axi4l_single_writer #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [DATA_BITS-1:0]   data,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             resp,
    output logic [ADDR_BITS-1:0]   m_awaddr,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_BITS-1:0]   m_wdata,
    output logic [DATA_BITS/8-1:0] m_wstrb,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready
);
    logic                 active_q, awvalid_q, wvalid_q, bready_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 hs_done;
    assign hs_done = (~awvalid_q | m_awready) & (~wvalid_q | m_wready);
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (start && !active_q) begin
            active_q  <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            addr_q    <= addr;
            data_q    <= data;
        end else begin
            if (m_awready) awvalid_q <= 1'b0;
            if (m_wready) wvalid_q <= 1'b0;
            if (active_q && !bready_q && hs_done) bready_q <= 1'b1;
            if (done) begin
                bready_q <= 1'b0;
                active_q <= 1'b0;
            end
        end
    end
    assign busy      = active_q;
    assign done      = bready_q & m_bvalid;
    assign resp      = m_bresp;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = data_q;
    assign m_wstrb   = '1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
endmodule

// File: rtl/exposure_scheduler.sv
// exposure_scheduler: per-frame AXI4-Lite reprogramming of the timing generator from an exposure table.
// Defining EXPOSURE_SCHEDULER_POL_EN adds tbl_pol and a trig0 polarity beat to every burst.
module exposure_scheduler
    import timing_generator_pkg::*;
#(
    parameter int ENTRIES     = 4,
    parameter int TIMER_BITS  = 32,
    parameter int FRAMES_BITS = 32,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [$clog2(ENTRIES):0]   num_entries,
    input  logic                       tbl_we,
    input  logic [$clog2(ENTRIES)-1:0] tbl_addr,
    input  logic [TIMER_BITS-1:0]      tbl_period,
    input  logic [TIMER_BITS-1:0]      tbl_start,
    input  logic [TIMER_BITS-1:0]      tbl_end,
`ifdef EXPOSURE_SCHEDULER_POL_EN
    input  logic                       tbl_pol,
`endif
    input  logic [FRAMES_BITS-1:0]     in_frames,
    output logic [ADDR_BITS-1:0]       m_awaddr,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [DATA_BITS-1:0]       m_wdata,
    output logic [DATA_BITS/8-1:0]     m_wstrb,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    input  logic [1:0]                 m_bresp,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    output logic                       busy,
    output logic [$clog2(ENTRIES)-1:0] cur_index,
    output logic                       err,
    output logic [15:0]                overrun_cnt
);
    localparam int IW = $clog2(ENTRIES);
    logic [TIMER_BITS-1:0]  period_q [ENTRIES];
    logic [TIMER_BITS-1:0]  start_q  [ENTRIES];
    logic [TIMER_BITS-1:0]  end_q    [ENTRIES];
`ifdef EXPOSURE_SCHEDULER_POL_EN
    logic                   pol_q    [ENTRIES];
`endif
    sched_state_e           state_q, state_d;
    logic                   en_q, pending_q, err_q;
    logic [FRAMES_BITS-1:0] frames_q;
    logic [IW-1:0]          idx_q, next_idx_q, cur_idx_q;
    logic [15:0]            ovr_q;
    logic                   start_ev, ev, go, wr_busy, wr_done;
    logic [1:0]             wr_resp;
    logic [IW:0]            eff, inc;
    int                     word;
    logic [DATA_BITS-1:0]   beat_data;
    always_ff @(posedge aclk) begin
        if (tbl_we) begin
            period_q[tbl_addr] <= tbl_period;
            start_q[tbl_addr]  <= tbl_start;
            end_q[tbl_addr]    <= tbl_end;
`ifdef EXPOSURE_SCHEDULER_POL_EN
            pol_q[tbl_addr]    <= tbl_pol;
`endif
        end
    end
    assign start_ev = enable & ~en_q;
    assign ev       = enable & (start_ev | (in_frames != frames_q));
    assign go       = ev | (enable & pending_q);
    assign eff      = num_entries == '0 ? (IW+1)'(1) :
                      num_entries > (IW+1)'(ENTRIES) ? (IW+1)'(ENTRIES) : num_entries;
    assign inc      = {1'b0, idx_q} + (IW+1)'(1);
    always_comb begin
        state_d   = state_q;
        word      = CTL_CONTROL;
        beat_data = DATA_BITS'(CTL_GO);
        case (state_q)
            S_IDLE: state_d = go ? S_PERIOD : S_IDLE;
            S_PERIOD: begin
                word      = PARAM_PERIOD;
                beat_data = DATA_BITS'(period_q[idx_q]);
                state_d   = wr_done ? S_START : state_q;
            end
            S_START: begin
                word      = TRIG0_START;
                beat_data = DATA_BITS'(start_q[idx_q]);
                state_d   = wr_done ? S_END : state_q;
            end
            S_END: begin
                word      = TRIG0_END;
                beat_data = DATA_BITS'(end_q[idx_q]);
`ifdef EXPOSURE_SCHEDULER_POL_EN
                state_d   = wr_done ? S_POL : state_q;
            end
            S_POL: begin
                word      = TRIG0_POL;
                beat_data = DATA_BITS'(pol_q[idx_q]);
`endif
                state_d   = wr_done ? S_CTL : state_q;
            end
            default: state_d = wr_done ? S_IDLE : state_q;
        endcase
    end
    // Pending is consumed on IDLE exit and dropped while disabled, so IDLE always clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            frames_q   <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= '0;
            idx_q      <= '0;
            next_idx_q <= '0;
            cur_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= enable;
            frames_q <= in_frames;
            if (state_q == S_IDLE) begin
                pending_q <= 1'b0;
                if (go) idx_q <= start_ev ? '0 : next_idx_q;
            end else if (ev) begin
                pending_q <= 1'b1;
                if (pending_q && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
            end
            if (wr_done && wr_resp != 2'b00) err_q <= 1'b1;
            if (wr_done && state_q == S_CTL) begin
                cur_idx_q  <= idx_q;
                next_idx_q <= inc >= eff ? '0 : inc[IW-1:0];
            end
            if (start_ev) next_idx_q <= '0;
        end
    end
    axi4l_single_writer #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_wr (
        .aclk(aclk), .aresetn(aresetn),
        .start(state_q != S_IDLE && !wr_busy),
        .addr(BASE_ADDR + ADDR_BITS'(byte_off(word))), .data(beat_data),
        .busy(wr_busy), .done(wr_done), .resp(wr_resp),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );
    assign busy        = state_q != S_IDLE;
    assign cur_index   = cur_idx_q;
    assign err         = err_q;
    assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_exposure_scheduler.sv
// tb_exposure_scheduler: random and directed stimulus against an entry-level model; AXI slave scoreboards writes.
module tb_exposure_scheduler;
    localparam int ENTRIES = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        enable = 1'b0, tbl_we = 1'b0, tbl_pol = 1'b0;
    logic [2:0]  num_entries = 3'd2;
    logic [1:0]  tbl_addr = '0;
    logic [31:0] tbl_period = '0, tbl_start = '0, tbl_end = '0, in_frames = '0;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, busy, err;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, cur_index;
    logic [15:0] overrun_cnt;
    always #5 clk = ~clk;

    exposure_scheduler dut (
        .aclk(clk), .aresetn(rst_n), .enable(enable), .num_entries(num_entries),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_period(tbl_period), .tbl_start(tbl_start),
        .tbl_end(tbl_end),
`ifdef EXPOSURE_SCHEDULER_POL_EN
        .tbl_pol(tbl_pol),
`endif
        .in_frames(in_frames),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .cur_index(cur_index), .err(err), .overrun_cnt(overrun_cnt)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; } exp_t;
    exp_t        exp_q[$];
    exp_t        e_cur;
    int          n_checks = 0, n_err = 0;
    logic [31:0] t_per[ENTRIES], t_sta[ENTRIES], t_end[ENTRIES];
    logic        t_pol[ENTRIES];
    int          m_next = 0, m_cur = 0, m_ovr = 0;
    logic        m_err = 1'b0;
    int          rand_mode = 0, bdelay = 0, aw_stall = 0;
    logic [31:0] err_addr = '1;
    logic        got_aw = 0, got_w = 0, cmp_done = 0, b_hs = 0, aw_after_w = 0;
    logic        prev_awv = 0, prev_aw_taken = 0;
    logic [31:0] prev_addr = '0, aw_addr = '0, w_data = '0;
    int          bcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_n(input int n);
        return n == 0 ? 1 : (n > ENTRIES ? ENTRIES : n);
    endfunction

    // Reference: one burst writes the entry's fields through the register map, then run+update.
    task automatic burst(input int e);
        exp_q.push_back('{32'h40, t_per[e]});
        exp_q.push_back('{32'h80, t_sta[e]});
        exp_q.push_back('{32'h84, t_end[e]});
`ifdef EXPOSURE_SCHEDULER_POL_EN
        exp_q.push_back('{32'h88, {31'b0, t_pol[e]}});
        if (err_addr == 32'h88) m_err = 1'b1;
`endif
        exp_q.push_back('{32'h10, 32'h3});
        if (err_addr inside {32'h40, 32'h80, 32'h84, 32'h10}) m_err = 1'b1;
        m_cur  = e;
        m_next = (e + 1) % eff_n(int'(num_entries));
    endtask

    task automatic write_tbl(input int i, input logic [31:0] p, input logic [31:0] s,
                             input logic [31:0] en, input logic pl);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 2'(i);
        tbl_period = p; tbl_start = s; tbl_end = en; tbl_pol = pl;
        @(negedge clk);
        tbl_we = 1'b0;
        t_per[i] = p; t_sta[i] = s; t_end[i] = en; t_pol[i] = pl;
    endtask

    task automatic frame_event();
        @(negedge clk);
        in_frames = in_frames + 32'($urandom_range(1, 1000));
        burst(m_next);
    endtask

    task automatic start_event();
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        burst(0);
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0, k = 0;
        while (quiet < 3 && k < 3000) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            k++;
        end
        if (quiet < 3) begin
            n_checks++; n_err++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles", nm, busy, k);
        end
        chk({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_cur_index"}, 32'(cur_index), 32'(m_cur));
        chk({nm, "_err"}, 32'(err), 32'(m_err));
        chk({nm, "_overrun"}, 32'(overrun_cnt), 32'(m_ovr));
    endtask

    // AXI slave + monitor: inputs chosen each negedge apply to the coming posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0;
                got_aw = 0; got_w = 0; cmp_done = 0; b_hs = 0; prev_awv = 0;
                continue;
            end
            if (b_hs) begin m_bvalid = 0; b_hs = 0; end
            if (m_bready) chk("bready_gate", {30'b0, got_aw, got_w}, 32'd3);
            if (got_aw && got_w && !cmp_done) begin
                cmp_done = 1;
                bcnt = rand_mode != 0 ? int'($urandom_range(0, 4)) : bdelay;
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL wr_unexpected: got write %0h=%0h expected none", aw_addr, w_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("wr_addr", aw_addr, e_cur.a);
                    chk("wr_data", w_data, e_cur.d);
                end
            end
            if (cmp_done && !m_bvalid && !b_hs) begin
                if (bcnt == 0) begin
                    m_bvalid = 1;
                    m_bresp  = aw_addr == err_addr ? 2'b10 : 2'b00;
                end else bcnt--;
            end
            if (m_bvalid && m_bready) begin b_hs = 1; got_aw = 0; got_w = 0; cmp_done = 0; end
            if (aw_stall > 0 && m_awvalid) begin
                m_awready = 0;
                aw_stall--;
            end else m_awready = rand_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_wready = rand_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_awvalid && prev_awv && !prev_aw_taken) chk("aw_stable", m_awaddr, prev_addr);
            prev_awv = m_awvalid; prev_addr = m_awaddr; prev_aw_taken = m_awvalid && m_awready;
            if (m_awvalid && m_awready) begin
                if (got_aw) chk("aw_single", 32'(got_aw), 32'd0);
                got_aw = 1; aw_addr = m_awaddr;
                if (got_w) aw_after_w = 1;
            end
            if (m_wvalid && m_wready) begin
                if (got_w) chk("w_single", 32'(got_w), 32'd0);
                got_w = 1; w_data = m_wdata;
                chk("wstrb", 32'(m_wstrb), 32'hF);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_awvalid", 32'(m_awvalid), 0);
        chk("rst_wvalid", 32'(m_wvalid), 0);
        chk("rst_bready", 32'(m_bready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_index", 32'(cur_index), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); in_frames = in_frames + 1;
            @(negedge clk);
            chk("dis_busy", 32'(busy), 0);
            chk("dis_awvalid", 32'(m_awvalid), 0);
        end
        chk("dis_overrun", 32'(overrun_cnt), 0);
        write_tbl(0, 100000, 1, 90000, 1'b1);
        write_tbl(1, 50000, 1, 40000, 1'b0);
        write_tbl(2, $urandom, $urandom, $urandom, 1'b0);
        write_tbl(3, $urandom, $urandom, $urandom, 1'b1);
        num_entries = 3'd2;
        @(negedge clk);
        enable = 1'b1;
        burst(0);
        wait_idle("start");
        frame_event();
        wait_idle("frame1");
        frame_event();
        wait_idle("wrap");
        aw_stall = 5; aw_after_w = 0;
        frame_event();
        wait_idle("aw_stall");
        chk("stall_w_first", 32'(aw_after_w), 1);
        chk("stall_consumed", 32'(aw_stall), 0);
        bdelay = 10;
        frame_event();
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            in_frames = in_frames + 1;
        end
        m_ovr = 2;
        burst(m_next);
        wait_idle("pending");
        bdelay = 0;
        err_addr = 32'h80;
        frame_event();
        wait_idle("bresp_err");
        err_addr = '1;
        frame_event();
        wait_idle("err_sticky");
        rand_mode = 1;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) write_tbl($urandom_range(0, ENTRIES-1), $urandom, $urandom, $urandom,
                                 1'($urandom_range(0, 1)));
            else if (r == 2) num_entries = 3'($urandom_range(0, 7));
            else begin
                if (r == 3) start_event(); else frame_event();
                wait_idle("rand");
            end
        end
        repeat (5) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 0);
        chk("final_overrun", 32'(overrun_cnt), 32'(m_ovr));
        chk("final_err", 32'(err), 32'(m_err));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
